// File: rtl/alu_writeback_seq_if.sv
// rtl/alu_writeback_seq_if.sv - instruction and register-file port bundle for alu_writeback_seq
//
// Signals:
//   START, OPCODE, RA, RB   instruction request from upstream
//   BUSY, DONE, ERR, FLAGS  sequencer status back to upstream
//   ADDR_A, ADDR_B          register file read addresses (ADDR_B also write address)
//   WR, DATA_IN             register file write enable / write data
//   SRC, DEST               register file read data for ADDR_A / ADDR_B
//
// Modports:
//   slave  - the sequencer (alu_writeback_seq)
//   master - the environment: instruction source plus the register file
interface alu_writeback_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              START;
    logic [3:0]        OPCODE;
    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [3:0]        FLAGS;
    logic [ADDR_W-1:0] ADDR_A;
    logic [ADDR_W-1:0] ADDR_B;
    logic              WR;
    logic [DATA_W-1:0] DATA_IN;
    logic [DATA_W-1:0] SRC;
    logic [DATA_W-1:0] DEST;

    modport slave (
        input  START, OPCODE, RA, RB, SRC, DEST,
        output BUSY, DONE, ERR, FLAGS, ADDR_A, ADDR_B, WR, DATA_IN
    );

    modport master (
        output START, OPCODE, RA, RB, SRC, DEST,
        input  BUSY, DONE, ERR, FLAGS, ADDR_A, ADDR_B, WR, DATA_IN
    );
endinterface

// File: rtl/alu_writeback_seq.sv
// rtl/alu_writeback_seq.sv - multi-cycle execute/writeback sequencer for an 8x16 register file
//
// Optional feature macro: ALU_SAT_EN
//   defined   - ADD/SUB saturate to the signed limits on overflow (V still set)
//   undefined - ADD/SUB wrap modulo 2^DATA_W
//
// Ports:
//   CLK   in   clock, rising edge
//   RSTn  in   synchronous active-low reset
//   bus   slave modport of alu_writeback_seq_if:
//           START/OPCODE/RA/RB in, BUSY/DONE/ERR/FLAGS out,
//           ADDR_A/ADDR_B/WR/DATA_IN out to the register file,
//           SRC/DEST in from the register file
//
// Flow: IDLE -> READ (capture operands) -> EXEC (1 cycle, or MUL_CYCLES for MUL)
//       -> WB (registered write/DONE/FLAGS appear the following cycle) -> IDLE
module alu_writeback_seq #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int NREGS      = 8,
    parameter int MUL_CYCLES = 16
) (
    input  logic               CLK,
    input  logic               RSTn,
    alu_writeback_seq_if.slave bus
);

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    localparam int                CNT_W     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MUL_CYCLES - 1);
    // One extra bit so NREGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W + 1)'(NREGS);
`ifdef ALU_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched instruction and register-file addresses
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   addr_a_q;
    logic [ADDR_W-1:0]   addr_b_q;

    // Operands captured in READ
    logic [DATA_W-1:0]   op_a_q;
    logic [DATA_W-1:0]   op_b_q;

    // Result and carry/overflow produced in EXEC, consumed in WB
    logic [DATA_W-1:0]   res_q;
    logic                c_q;
    logic                v_q;

    // Shift-add multiplier state
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    mul_cnt_q;
    logic [2*DATA_W-1:0] acc_next;
    logic                mul_last;

    // Registered outputs
    logic                wr_q;
    logic [DATA_W-1:0]   data_in_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [3:0]          flags_q;

    // Combinational ALU
    logic                start_legal;
    logic [DATA_W:0]     sum_w;
    logic [DATA_W:0]     diff_w;
    logic [DATA_W:0]     shl_w;
    logic [DATA_W:0]     shr_w;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                alu_v;
    logic                add_ovf;
    logic                sub_ovf;

    assign start_legal = (bus.OPCODE <= OP_MUL)
                      && ({1'b0, bus.RA} < REG_LIMIT)
                      && ({1'b0, bus.RB} < REG_LIMIT);

    assign mul_last = (mul_cnt_q == CNT_LAST);
    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Extra top bit of sum/diff is the carry-out / borrow.
    assign sum_w  = {1'b0, op_b_q} + {1'b0, op_a_q};
    assign diff_w = {1'b0, op_b_q} - {1'b0, op_a_q};

    // One guard bit beside the data catches the last bit shifted out;
    // with a zero shift amount the guard bit stays 0.
    assign shl_w = {1'b0, op_b_q} << op_a_q[3:0];
    assign shr_w = {op_b_q, 1'b0} >> op_a_q[3:0];

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the
    // result sign differs from opB.
    assign add_ovf = (op_b_q[DATA_W-1] == op_a_q[DATA_W-1])
                  && (sum_w[DATA_W-1] != op_b_q[DATA_W-1]);
    assign sub_ovf = (op_b_q[DATA_W-1] != op_a_q[DATA_W-1])
                  && (diff_w[DATA_W-1] != op_b_q[DATA_W-1]);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_MOV: alu_res = op_a_q;
            OP_ADD: begin
                alu_res = sum_w[DATA_W-1:0];
                alu_c   = sum_w[DATA_W];
                alu_v   = add_ovf;
`ifdef ALU_SAT_EN
                // Overflow direction follows opB's sign.
                if (add_ovf) alu_res = op_b_q[DATA_W-1] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_SUB: begin
                alu_res = diff_w[DATA_W-1:0];
                alu_c   = diff_w[DATA_W];
                alu_v   = sub_ovf;
`ifdef ALU_SAT_EN
                if (sub_ovf) alu_res = op_b_q[DATA_W-1] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_AND: alu_res = op_b_q & op_a_q;
            OP_OR:  alu_res = op_b_q | op_a_q;
            OP_XOR: alu_res = op_b_q ^ op_a_q;
            OP_NOT: alu_res = ~op_a_q;
            OP_SHL: begin
                alu_res = shl_w[DATA_W-1:0];
                alu_c   = shl_w[DATA_W];
            end
            OP_SHR: begin
                alu_res = shr_w[DATA_W:1];
                alu_c   = shr_w[0];
            end
            OP_CMP: begin
                // Compare never saturates; the difference only feeds the flags.
                alu_res = diff_w[DATA_W-1:0];
                alu_c   = diff_w[DATA_W];
                alu_v   = sub_ovf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.START && start_legal) state_d = S_READ;
            S_READ: state_d = S_EXEC;
            S_EXEC: if ((op_q != OP_MUL) || mul_last) state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            op_q      <= OP_MOV;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            res_q     <= '0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            mul_cnt_q <= '0;
            wr_q      <= 1'b0;
            data_in_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            flags_q   <= 4'd0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        // A rejected instruction leaves the address outputs
                        // untouched so the register file never sees an
                        // out-of-range index.
                        if (start_legal) begin
                            op_q     <= bus.OPCODE;
                            addr_a_q <= bus.RA;
                            addr_b_q <= bus.RB;
                            busy_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    op_a_q    <= bus.SRC;
                    op_b_q    <= bus.DEST;
                    acc_q     <= '0;
                    mcand_q   <= {{DATA_W{1'b0}}, bus.DEST};
                    mplier_q  <= bus.SRC;
                    mul_cnt_q <= '0;
                end
                S_EXEC: begin
                    if (op_q == OP_MUL) begin
                        acc_q     <= acc_next;
                        mcand_q   <= mcand_q << 1;
                        mplier_q  <= mplier_q >> 1;
                        mul_cnt_q <= mul_cnt_q + 1'b1;
                        if (mul_last) begin
                            res_q <= acc_next[DATA_W-1:0];
                            c_q   <= |acc_next[2*DATA_W-1:DATA_W];
                            v_q   <= 1'b0;
                        end
                    end else begin
                        res_q <= alu_res;
                        c_q   <= alu_c;
                        v_q   <= alu_v;
                    end
                end
                S_WB: begin
                    wr_q      <= (op_q != OP_CMP);
                    data_in_q <= res_q;
                    flags_q   <= {(res_q == '0), res_q[DATA_W-1], c_q, v_q};
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ADDR_A  = addr_a_q;
    assign bus.ADDR_B  = addr_b_q;
    assign bus.WR      = wr_q;
    assign bus.DATA_IN = data_in_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;
    assign bus.FLAGS   = flags_q;

endmodule

// File: tb/tb_alu_writeback_seq.sv
// tb/tb_alu_writeback_seq.sv - scoreboard testbench for alu_writeback_seq
module tb_alu_writeback_seq;
    localparam int DW = 16;
    localparam int AW = 4;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    typedef struct {
        bit          seen;
        int          lat;
        int          busy;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [3:0]  flags;
    } obs_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    exp_t        sbq[$];
    logic [15:0] sh [8];
    logic [3:0]  exp_flags = 4'd0;

    logic [15:0] rf [8];
    logic        pl_en   = 1'b0;
    logic [2:0]  pl_addr = 3'd0;
    logic [15:0] pl_data = 16'd0;

    always #5 clk = ~clk;

    alu_writeback_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    alu_writeback_seq #(.DATA_W(DW), .ADDR_W(AW), .NREGS(8), .MUL_CYCLES(16)) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    // Register file: combinational reads, write on rising edge.
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (bus.WR && (bus.ADDR_B < 4'd8)) rf[bus.ADDR_B[2:0]] <= bus.DATA_IN;
    end
    assign bus.SRC  = (bus.ADDR_A < 4'd8) ? rf[bus.ADDR_A[2:0]] : 16'h0000;
    assign bus.DEST = (bus.ADDR_B < 4'd8) ? rf[bus.ADDR_B[2:0]] : 16'h0000;

    // Reference model: returns {Z,N,C,V, result}
    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        c;
        logic        v;
        logic [31:0] p;
        int          sa;
        int          sb;
        int          ss;
        r = 16'h0; c = 1'b0; v = 1'b0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'd0: r = a;
            4'd1: begin
                p  = {16'h0, b} + {16'h0, a};
                r  = p[15:0];
                c  = p[16];
                ss = sb + sa;
                v  = (ss > 32767) || (ss < -32768);
`ifdef ALU_SAT_EN
                if (v) r = (ss > 0) ? 16'h7FFF : 16'h8000;
`endif
            end
            4'd2, 4'd9: begin
                r  = b - a;
                c  = (b < a);
                ss = sb - sa;
                v  = (ss > 32767) || (ss < -32768);
`ifdef ALU_SAT_EN
                if (v && op == 4'd2) r = (ss > 0) ? 16'h7FFF : 16'h8000;
`endif
            end
            4'd3: r = b & a;
            4'd4: r = b | a;
            4'd5: r = b ^ a;
            4'd6: r = ~a;
            4'd7: begin
                r = b;
                for (int i = 0; i < int'(a[3:0]); i++) begin c = r[15]; r = r << 1; end
            end
            4'd8: begin
                r = b;
                for (int i = 0; i < int'(a[3:0]); i++) begin c = r[0]; r = r >> 1; end
            end
            4'd10: begin
                p = {16'h0, a} * {16'h0, b};
                r = p[15:0];
                c = (p[31:16] != 16'h0);
            end
            default: ;
        endcase
        return {(r == 16'h0), r[15], c, v, r};
    endfunction

    task automatic preload(input int idx, input logic [15:0] v);
        pl_en   = 1'b1;
        pl_addr = 3'(idx);
        pl_data = v;
        @(negedge clk);
        pl_en   = 1'b0;
        sh[idx] = v;
    endtask

    // Drives one instruction from the current negedge and waits (bounded) for DONE.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                             input bit spam, output obs_t o);
        o.seen = 1'b0; o.lat = -1; o.busy = 0;
        o.wr = 1'b0; o.addr = 4'h0; o.data = 16'h0; o.flags = 4'h0;
        bus.START = 1'b1; bus.OPCODE = op; bus.RA = ra; bus.RB = rb;
        @(negedge clk);
        bus.START = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.BUSY) o.busy++;
            if (bus.DONE) begin
                o.seen = 1'b1; o.lat = c; o.wr = bus.WR; o.addr = bus.ADDR_B;
                o.data = bus.DATA_IN; o.flags = bus.FLAGS;
                break;
            end
            if (spam && bus.BUSY) begin
                bus.START = 1'b1; bus.OPCODE = 4'd1; bus.RA = 4'd0; bus.RB = 4'd0;
            end else begin
                bus.START = 1'b0;
            end
            @(negedge clk);
        end
        bus.START = 1'b0;
    endtask

    // Pushes the model's expectation, runs the instruction, pops the expectation.
    task automatic issue(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input bit spam, output exp_t e, output obs_t o);
        logic [19:0] m;
        exp_t        x;
        m       = model(op, sh[ra[2:0]], sh[rb[2:0]]);
        x.wr    = (op != 4'd9);
        x.addr  = rb;
        x.data  = m[15:0];
        x.flags = m[19:16];
        x.lat   = (op == 4'd10) ? 18 : 3;
        sbq.push_back(x);
        if (x.wr) sh[rb[2:0]] = m[15:0];
        run_instr(op, ra, rb, spam, o);
        e = sbq.pop_front();
        exp_flags = e.flags;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.START = 1'b0; bus.OPCODE = 4'd0; bus.RA = 4'd0; bus.RB = 4'd0;
        for (int i = 0; i < 8; i++) preload(i, 16'h0000);
        tests_run++;
        if ({bus.ADDR_A, bus.ADDR_B} !== 8'h00) begin
            tests_failed++; $display("FAIL reset_addr: got %h, expected 00", {bus.ADDR_A, bus.ADDR_B});
        end
        tests_run++;
        if ({bus.WR, bus.BUSY, bus.DONE, bus.ERR} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b, expected 0000", {bus.WR, bus.BUSY, bus.DONE, bus.ERR});
        end
        tests_run++;
        if (bus.DATA_IN !== 16'h0 || bus.FLAGS !== 4'h0) begin
            tests_failed++; $display("FAIL reset_data: got data=%h flags=%b, expected 0000/0000", bus.DATA_IN, bus.FLAGS);
        end
        rstn = 1'b1;
        exp_flags = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_add();
        exp_t e; obs_t o;
        preload(1, 16'h0003);
        preload(2, 16'h0005);
        issue(4'd1, 4'd1, 4'd2, 1'b0, e, o);
        tests_run++;
        if (!o.seen || o.lat !== e.lat || o.busy !== 3) begin
            tests_failed++; $display("FAIL add_latency: got seen=%0d lat=%0d busy=%0d, expected lat=%0d busy=3", o.seen, o.lat, o.busy, e.lat);
        end
        tests_run++;
        if ({o.wr, o.addr, o.data} !== {1'b1, 4'd2, 16'h0008} || o.data !== e.data) begin
            tests_failed++; $display("FAIL add_write: got wr=%b addr=%0d data=%h, expected 1/2/0008", o.wr, o.addr, o.data);
        end
        tests_run++;
        if (o.flags !== 4'b0000) begin
            tests_failed++; $display("FAIL add_flags: got %b, expected 0000", o.flags);
        end
    endtask

    task automatic test_add_overflow();
        exp_t e; obs_t o;
        logic [15:0] want_data;
        logic [3:0]  want_flags;
`ifdef ALU_SAT_EN
        want_data = 16'h7FFF; want_flags = 4'b0001;
`else
        want_data = 16'h8000; want_flags = 4'b0101;
`endif
        preload(1, 16'h0001);
        preload(2, 16'h7FFF);
        issue(4'd1, 4'd1, 4'd2, 1'b0, e, o);
        tests_run++;
        if (!o.seen || o.data !== want_data || o.data !== e.data || o.wr !== 1'b1) begin
            tests_failed++; $display("FAIL add_ovf_data: got seen=%0d wr=%b data=%h, expected %h", o.seen, o.wr, o.data, want_data);
        end
        tests_run++;
        if (o.flags !== want_flags) begin
            tests_failed++; $display("FAIL add_ovf_flags: got %b, expected %b", o.flags, want_flags);
        end
        // SUB negative overflow: 0x8000 - 1
        preload(1, 16'h0001);
        preload(2, 16'h8000);
        issue(4'd2, 4'd1, 4'd2, 1'b0, e, o);
        tests_run++;
        if (!o.seen || o.data !== e.data || o.flags !== e.flags) begin
            tests_failed++; $display("FAIL sub_ovf: got data=%h flags=%b, expected %h/%b", o.data, o.flags, e.data, e.flags);
        end
    endtask

    task automatic test_cmp();
        exp_t e; obs_t o;
        preload(1, 16'h0005);
        preload(2, 16'h0005);
        issue(4'd9, 4'd1, 4'd2, 1'b0, e, o);
        tests_run++;
        if (!o.seen || o.lat !== 3 || o.wr !== 1'b0) begin
            tests_failed++; $display("FAIL cmp_nowrite: got seen=%0d lat=%0d wr=%b, expected lat=3 wr=0", o.seen, o.lat, o.wr);
        end
        tests_run++;
        if (o.flags !== 4'b1000 || o.flags !== e.flags) begin
            tests_failed++; $display("FAIL cmp_flags: got %b, expected 1000", o.flags);
        end
        @(negedge clk);
        tests_run++;
        if (rf[2] !== 16'h0005) begin
            tests_failed++; $display("FAIL cmp_reg: got R2=%h, expected 0005", rf[2]);
        end
    endtask

    task automatic test_mul();
        exp_t e; obs_t o;
        int   stray;
        preload(3, 16'h0100);
        preload(4, 16'h0300);
        issue(4'd10, 4'd3, 4'd4, 1'b1, e, o);
        tests_run++;
        if (!o.seen || o.lat !== 18 || o.busy !== 18) begin
            tests_failed++; $display("FAIL mul_latency: got seen=%0d lat=%0d busy=%0d, expected 18/18", o.seen, o.lat, o.busy);
        end
        tests_run++;
        if ({o.wr, o.addr, o.data} !== {1'b1, 4'd4, 16'h0000} || o.flags !== 4'b1010) begin
            tests_failed++; $display("FAIL mul_result: got wr=%b addr=%0d data=%h flags=%b, expected 1/4/0000/1010", o.wr, o.addr, o.data, o.flags);
        end
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.DONE || bus.BUSY || bus.WR) stray++;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++; $display("FAIL mul_ignore_start: got %0d active cycles after MUL, expected 0", stray);
        end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 3; k++) begin
            bus.START  = 1'b1;
            bus.OPCODE = (k == 0) ? 4'hF : 4'd1;
            bus.RA     = (k == 1) ? 4'd9 : 4'd1;
            bus.RB     = (k == 2) ? 4'd8 : 4'd2;
            @(negedge clk);
            bus.START = 1'b0;
            tests_run++;
            if ({bus.ERR, bus.BUSY, bus.WR, bus.DONE} !== 4'b1000 || bus.FLAGS !== exp_flags) begin
                tests_failed++; $display("FAIL illegal_%0d_err: got err/busy/wr/done=%b flags=%b, expected 1000 flags=%b", k, {bus.ERR, bus.BUSY, bus.WR, bus.DONE}, bus.FLAGS, exp_flags);
            end
            @(negedge clk);
            tests_run++;
            if ({bus.ERR, bus.BUSY, bus.WR, bus.DONE} !== 4'b0000) begin
                tests_failed++; $display("FAIL illegal_%0d_after: got %b, expected 0000", k, {bus.ERR, bus.BUSY, bus.WR, bus.DONE});
            end
        end
    endtask

    task automatic test_op_sweep();
        exp_t e; obs_t o;
        logic [15:0] va;
        logic [15:0] vb;
        for (int pass = 0; pass < 2; pass++) begin
            for (int op = 0; op <= 10; op++) begin
                va = (pass == 0) ? 16'h0013 : 16'($urandom);
                vb = (pass == 0) ? 16'hA5C3 : 16'($urandom);
                preload(5, va);
                preload(6, vb);
                issue(4'(op), 4'd5, 4'd6, 1'b0, e, o);
                tests_run++;
                if (!o.seen || o.lat !== e.lat || {o.wr, o.addr, o.data, o.flags} !== {e.wr, e.addr, e.data, e.flags}) begin
                    tests_failed++;
                    $display("FAIL sweep_op%0d: a=%h b=%h got lat=%0d wr=%b data=%h flags=%b, expected lat=%0d wr=%b data=%h flags=%b",
                             op, va, vb, o.lat, o.wr, o.data, o.flags, e.lat, e.wr, e.data, e.flags);
                end
            end
        end
        // Shift by zero: result unchanged, C=0
        preload(5, 16'h0010);
        preload(6, 16'h8001);
        issue(4'd7, 4'd5, 4'd6, 1'b0, e, o);
        tests_run++;
        if (o.data !== 16'h8001 || o.flags !== 4'b0100) begin
            tests_failed++; $display("FAIL shl_zero: got data=%h flags=%b, expected 8001/0100", o.data, o.flags);
        end
        // RA==RB and a write to register 0
        preload(7, 16'h4000);
        issue(4'd1, 4'd7, 4'd7, 1'b0, e, o);
        tests_run++;
        if (o.data !== e.data || o.flags !== e.flags || o.addr !== 4'd7) begin
            tests_failed++; $display("FAIL same_reg: got data=%h flags=%b, expected %h/%b", o.data, o.flags, e.data, e.flags);
        end
        issue(4'd0, 4'd7, 4'd0, 1'b0, e, o);
        @(negedge clk);
        tests_run++;
        if (rf[0] !== sh[0] || o.wr !== 1'b1 || o.addr !== 4'd0) begin
            tests_failed++; $display("FAIL write_r0: got R0=%h wr=%b addr=%0d, expected %h", rf[0], o.wr, o.addr, sh[0]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; obs_t o;
        logic [3:0] ops [4];
        logic [3:0] ras [4];
        logic [3:0] rbs [4];
        ops = '{4'd1, 4'd1, 4'd2, 4'd5};
        ras = '{4'd1, 4'd1, 4'd2, 4'd1};
        rbs = '{4'd2, 4'd2, 4'd1, 4'd2};
        preload(1, 16'h0001);
        preload(2, 16'h0002);
        // Each issue starts on the DONE cycle of the previous one.
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], ras[i], rbs[i], 1'b0, e, o);
            tests_run++;
            if (!o.seen || o.lat !== 3 || o.data !== e.data || o.flags !== e.flags) begin
                tests_failed++; $display("FAIL b2b_%0d: got seen=%0d lat=%0d data=%h flags=%b, expected lat=3 data=%h flags=%b", i, o.seen, o.lat, o.data, o.flags, e.data, e.flags);
            end
        end
        @(negedge clk);
        tests_run++;
        if (rf[1] !== sh[1] || rf[2] !== sh[2]) begin
            tests_failed++; $display("FAIL b2b_regs: got R1=%h R2=%h, expected %h %h", rf[1], rf[2], sh[1], sh[2]);
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t e; obs_t o;
        int   act;
        preload(3, 16'h0100);
        preload(4, 16'h0300);
        bus.START = 1'b1; bus.OPCODE = 4'd10; bus.RA = 4'd3; bus.RB = 4'd4;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.ADDR_A, bus.ADDR_B, bus.WR, bus.BUSY, bus.DONE, bus.ERR, bus.FLAGS} !== 16'h0000 || bus.DATA_IN !== 16'h0) begin
            tests_failed++; $display("FAIL midreset_outputs: got addr=%h/%h ctrl=%b data=%h flags=%b, expected all 0",
                                     bus.ADDR_A, bus.ADDR_B, {bus.WR, bus.BUSY, bus.DONE, bus.ERR}, bus.DATA_IN, bus.FLAGS);
        end
        rstn = 1'b1;
        exp_flags = 4'd0;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.WR || bus.DONE || bus.BUSY) act++;
        end
        tests_run++;
        if (act !== 0 || rf[4] !== 16'h0300) begin
            tests_failed++; $display("FAIL midreset_nowrite: got %0d active cycles R4=%h, expected 0 and 0300", act, rf[4]);
        end
        preload(1, 16'h1234);
        preload(2, 16'h0101);
        issue(4'd1, 4'd1, 4'd2, 1'b0, e, o);
        tests_run++;
        if (!o.seen || o.lat !== 3 || o.data !== 16'h1335 || o.data !== e.data || o.flags !== e.flags) begin
            tests_failed++; $display("FAIL midreset_add: got seen=%0d lat=%0d data=%h flags=%b, expected lat=3 data=1335 flags=%b", o.seen, o.lat, o.data, o.flags, e.flags);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_overflow();
        test_cmp();
        test_mul();
        test_illegal();
        test_op_sweep();
        test_back_to_back();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
